axilite_timer_regs: RTL and testbench
=====================================

AXILITE_TIMER_REGS -- requirements
Module: axilite_timer_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have write-address ports: aw_addr in ADDR_WIDTH, aw_prot in 3, aw_valid in 1, aw_ready out 1.
REQ-006 SHALL have write-data ports: w_data in DATA_WIDTH, w_strb in 4, w_valid in 1, w_ready out 1.
REQ-007 SHALL have write-response ports: b_resp out 2, b_valid out 1, b_ready in 1.
REQ-008 SHALL have read-address ports: ar_addr in ADDR_WIDTH, ar_prot in 3, ar_valid in 1, ar_ready out 1.
REQ-009 SHALL have read-data ports: r_data out DATA_WIDTH, r_resp out 2, r_valid out 1, r_ready in 1.
REQ-010 SHALL have port cnt_strobe  output  1  one-cycle pulse when CNT is written.
REQ-011 SHALL have ports cnt_ena, cnt_udt and cnt_ien  output  1 each  CNT bits 0, 1 and 2 (enable, up/down, interrupt enable).
REQ-012 SHALL have port tlr_strobe  output  1  one-cycle pulse when TLR is written.
REQ-013 SHALL have port tlr_tlr  output  32  load-value register.
REQ-014 SHALL have port tcr_strobe  output  1  one-cycle pulse when a TCR read is accepted.
REQ-015 SHALL have port tcr_tcr  input  32  live counter value from the timer core.
REQ-016 SHALL have port tir_zero_set  input  1  counter-reached-zero event.
REQ-017 SHALL have port irq  output  1  TIR[0] AND cnt_ien.

Function
REQ-018 SHALL decode the address map from addr[3:2]: 0x00 CNT (rw), 0x04 TLR (rw), 0x08 TCR (ro), 0x0C TIR (bit0, W1C); addresses >= 0x10 or writes to TCR SHALL return SLVERR (2'b10) with no side effect; all other accesses return OKAY.
REQ-019 SHALL accept the AW and W channels independently and in either order, each into a one-entry holding register; aw_ready (or w_ready) SHALL be high only while that holding register is empty and b_valid is low.
REQ-020 SHALL commit a write on the cycle after both holding registers are full; b_valid SHALL assert on the same edge and hold, with stable b_resp, until b_ready is high; then both holding registers clear.
REQ-021 SHALL apply writes to CNT and TLR byte-wise per w_strb; cnt_strobe or tlr_strobe SHALL pulse for exactly one cycle at commit, even when w_strb is zero.
REQ-022 SHALL hold ar_ready high while r_valid is low; on ar_valid&&ar_ready, r_valid and r_data SHALL be registered on the next edge and held stable until r_ready is high.
REQ-023 SHALL return unused CNT/TIR bits as 0; a TCR read SHALL return tcr_tcr sampled at address acceptance.
REQ-024 SHALL set TIR[0] when tir_zero_set is high; if set and W1C coincide, set SHALL win.
REQ-025 SHALL let a read that completes in the same cycle as a write commit return the pre-write value.

Reset
REQ-026 SHALL, while rst is low, clear all registers and drive all of the following low/zero: aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp, all strobes, cnt_*, tlr_tlr, TIR and irq.
REQ-027 SHALL, on reset assertion in mid-transaction, discard any held address, data or response; ready signals SHALL rise on the first edge after rst deasserts.

Configuration
REQ-028 SHALL, when AXILITE_TIMER_PROT_CHK_EN is defined, answer any access with prot[0]==0 (unprivileged) with SLVERR: writes SHALL have no effect, and reads SHALL return r_data 0 with no tcr_strobe.
REQ-029 SHALL, when AXILITE_TIMER_PROT_CHK_EN is undefined, ignore aw_prot and ar_prot.

Verification
REQ-030 SHALL include: AW 0x04, then W 0xDEADBEEF with strb 0xF two cycles later -> one tlr_strobe pulse, tlr_tlr=0xDEADBEEF, b_resp=00.
REQ-031 SHALL include: W 0x00000007 before AW 0x00, with b_ready held low 3 cycles -> cnt_ena/udt/ien=1, b_valid held 3 cycles, aw_ready/w_ready low meanwhile.
REQ-032 SHALL include: tcr_tcr=0x12345678, read 0x08 with r_ready low 2 cycles -> r_data stays 0x12345678, one tcr_strobe pulse, r_resp=00.
REQ-033 SHALL include: tir_zero_set and W1C to 0x0C in the same cycle with ien=1 -> TIR[0] stays 1, irq=1; a later W1C alone -> irq=0.
REQ-034 SHALL include: write 0x20 and write 0x08 -> b_resp=10 each, no strobes; with PROT_CHK_EN, write 0x04 with aw_prot=0 -> b_resp=10 and tlr_tlr unchanged.
REQ-035 SHALL include: rst low while AW is held -> b_valid=0; after release, a fresh write to 0x04 -> correct completion.

Source files
------------

// File: rtl/axilite_timer_regs.sv
// axilite_timer_regs -- AXI4-Lite register slave for a simple timer core.
//
// Register map (decoded from addr[3:2], anything at or above 0x10 is SLVERR):
//   0x00 CNT  rw  [0] enable, [1] up/down, [2] interrupt enable
//   0x04 TLR  rw  32-bit load value
//   0x08 TCR  ro  live counter from the timer core (writes -> SLVERR)
//   0x0C TIR  [0] zero-reached flag, write-1-to-clear, hardware set wins
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   aw_* / w_* / b_*         AXI-Lite write channels (AW and W accepted independently)
//   ar_* / r_*               AXI-Lite read channels
//   cnt_strobe, cnt_ena/udt/ien   CNT write pulse and CNT bits
//   tlr_strobe, tlr_tlr      TLR write pulse and load value
//   tcr_strobe, tcr_tcr      TCR read-accept pulse and live counter input
//   tir_zero_set, irq        zero event input, interrupt (TIR[0] & ien)
//
// Build option: define AXILITE_TIMER_PROT_CHK_EN to reject unprivileged
// accesses (prot[0]==0) with SLVERR and no side effects.
module axilite_timer_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic [2:0]            aw_prot,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [3:0]            w_strb,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic [1:0]            b_resp,
    output logic                  b_valid,
    input  logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [2:0]            ar_prot,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [1:0]            r_resp,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic                  cnt_strobe,
    output logic                  cnt_ena,
    output logic                  cnt_udt,
    output logic                  cnt_ien,
    output logic                  tlr_strobe,
    output logic [31:0]           tlr_tlr,
    output logic                  tcr_strobe,
    input  logic [31:0]           tcr_tcr,
    input  logic                  tir_zero_set,
    output logic                  irq
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] IDX_CNT = 2'd0;
    localparam logic [1:0] IDX_TLR = 2'd1;
    localparam logic [1:0] IDX_TCR = 2'd2;
    localparam logic [1:0] IDX_TIR = 2'd3;

    // Low through reset, high from the first edge after release; keeps all
    // ready outputs low while in reset without registering each one.
    logic                  live;
    logic                  aw_full, w_full;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [2:0]            aw_prot_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [3:0]            w_strb_q;
    logic [2:0]            cnt_q;
    logic [31:0]           tlr_q;
    logic                  tir_q;

    assign aw_ready = live && !aw_full && !b_valid;
    assign w_ready  = live && !w_full  && !b_valid;
    assign ar_ready = live && !r_valid;

    logic wr_priv_ok, rd_priv_ok;
`ifdef AXILITE_TIMER_PROT_CHK_EN
    assign wr_priv_ok = aw_prot_q[0];
    assign rd_priv_ok = ar_prot[0];
`else
    assign wr_priv_ok = 1'b1;
    assign rd_priv_ok = 1'b1;
`endif

    // Bits with no function in every build; collected so nothing dangles.
    logic unused_bits;
    assign unused_bits = ^{aw_prot_q, ar_prot, aw_addr_q[1:0], ar_addr[1:0]};

    // Write decode works off the holding registers; commit fires once, on the
    // cycle after both halves are present, and b_valid blocks a repeat.
    logic [1:0] wr_idx, rd_idx;
    logic       commit, wr_ok, wr_cnt, wr_tlr, w1c;
    assign wr_idx = aw_addr_q[3:2];
    assign commit = aw_full && w_full && !b_valid;
    assign wr_ok  = (aw_addr_q[ADDR_WIDTH-1:4] == '0) && (wr_idx != IDX_TCR) && wr_priv_ok;
    assign wr_cnt = commit && wr_ok && (wr_idx == IDX_CNT);
    assign wr_tlr = commit && wr_ok && (wr_idx == IDX_TLR);
    assign w1c    = commit && wr_ok && (wr_idx == IDX_TIR) && w_strb_q[0] && w_data_q[0];

    logic                  rd_hs, rd_ok;
    logic [DATA_WIDTH-1:0] rd_mux;
    assign rd_idx = ar_addr[3:2];
    assign rd_hs  = ar_valid && ar_ready;
    assign rd_ok  = (ar_addr[ADDR_WIDTH-1:4] == '0) && rd_priv_ok;

    // Read data comes from current register state, so a read accepted on a
    // commit edge sees the pre-write value.
    always_comb begin
        rd_mux = '0;
        if (rd_ok) begin
            case (rd_idx)
                IDX_CNT: rd_mux[2:0] = cnt_q;
                IDX_TLR: rd_mux      = tlr_q;
                IDX_TCR: rd_mux      = tcr_tcr;
                default: rd_mux[0]   = tir_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live       <= 1'b0;
            aw_full    <= 1'b0;
            aw_addr_q  <= '0;
            aw_prot_q  <= '0;
            w_full     <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid    <= 1'b0;
            b_resp     <= RESP_OKAY;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_resp     <= RESP_OKAY;
            cnt_q      <= '0;
            tlr_q      <= '0;
            tir_q      <= 1'b0;
            cnt_strobe <= 1'b0;
            tlr_strobe <= 1'b0;
            tcr_strobe <= 1'b0;
        end else begin
            live       <= 1'b1;
            cnt_strobe <= wr_cnt;
            tlr_strobe <= wr_tlr;
            tcr_strobe <= rd_hs && rd_ok && (rd_idx == IDX_TCR);

            if (aw_valid && aw_ready) begin
                aw_full   <= 1'b1;
                aw_addr_q <= aw_addr;
                aw_prot_q <= aw_prot;
            end
            if (w_valid && w_ready) begin
                w_full   <= 1'b1;
                w_data_q <= w_data;
                w_strb_q <= w_strb;
            end

            if (commit) begin
                b_valid <= 1'b1;
                b_resp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (b_valid && b_ready) begin
                b_valid <= 1'b0;
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end

            if (wr_cnt && w_strb_q[0])
                cnt_q <= w_data_q[2:0];
            for (int i = 0; i < 4; i++)
                if (wr_tlr && w_strb_q[i])
                    tlr_q[8*i +: 8] <= w_data_q[8*i +: 8];

            if (tir_zero_set)
                tir_q <= 1'b1;
            else if (w1c)
                tir_q <= 1'b0;

            if (rd_hs) begin
                r_valid <= 1'b1;
                r_data  <= rd_mux;
                r_resp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign cnt_ena = cnt_q[0];
    assign cnt_udt = cnt_q[1];
    assign cnt_ien = cnt_q[2];
    assign tlr_tlr = tlr_q;
    assign irq     = tir_q & cnt_q[2];
endmodule

// File: tb/tb_axilite_timer_regs.sv
// Scoreboard bench for axilite_timer_regs: drivers push expected responses
// from a register-level model, monitors pop them on each B/R handshake.
module tb_axilite_timer_regs;
    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0, tcr_tcr = '0;
    logic [2:0]  aw_prot = '0, ar_prot = '0;
    logic [3:0]  w_strb = '0;
    logic        aw_valid = 0, w_valid = 0, b_ready = 0, ar_valid = 0, r_ready = 0, tir_zero_set = 0;
    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic [1:0]  b_resp, r_resp;
    logic [31:0] r_data, tlr_tlr;
    logic        cnt_strobe, cnt_ena, cnt_udt, cnt_ien, tlr_strobe, tcr_strobe, irq;

    always #5 clk = ~clk;

    axilite_timer_regs dut (
        .clk(clk), .rst(rst),
        .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
        .cnt_strobe(cnt_strobe), .cnt_ena(cnt_ena), .cnt_udt(cnt_udt), .cnt_ien(cnt_ien),
        .tlr_strobe(tlr_strobe), .tlr_tlr(tlr_tlr), .tcr_strobe(tcr_strobe), .tcr_tcr(tcr_tcr),
        .tir_zero_set(tir_zero_set), .irq(irq)
    );

    int total = 0, passed = 0;
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask
    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s (bound expired or unexpected event)", name);
    endtask

    // ---------------- reference model ----------------
    logic [2:0]  m_cnt = '0;
    logic [31:0] m_tlr = '0;
    logic        m_tir = 0;
    int e_cnt_stb = 0, e_tlr_stb = 0, e_tcr_stb = 0;
    int n_cnt_stb = 0, n_tlr_stb = 0, n_tcr_stb = 0;

    function automatic bit prot_ok(input logic [2:0] p);
`ifdef AXILITE_TIMER_PROT_CHK_EN
        return p[0];
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_write(input logic [31:0] a, d, input logic [3:0] s,
                               input logic [2:0] p, output logic [1:0] resp);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (a >= 32'h10 || a[3:2] == 2'd2 || !prot_ok(p)) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            case (a[3:2])
                2'd0: begin m_cnt = (m_cnt & ~mask[2:0]) | (d[2:0] & mask[2:0]); e_cnt_stb++; end
                2'd1: begin m_tlr = (m_tlr & ~mask) | (d & mask); e_tlr_stb++; end
                default: if (mask[0] && d[0] && !tir_zero_set) m_tir = 1'b0;
            endcase
        end
    endtask

    function automatic logic [33:0] model_read(input logic [31:0] a, input logic [2:0] p);
        if (a >= 32'h10 || !prot_ok(p)) return {2'b10, 32'h0};
        case (a[3:2])
            2'd0:    return {2'b00, 29'h0, m_cnt};
            2'd1:    return {2'b00, m_tlr};
            2'd2:    return {2'b00, tcr_tcr};
            default: return {2'b00, 31'h0, m_tir};
        endcase
    endfunction

    // ---------------- scoreboard monitors ----------------
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    always @(negedge clk) begin
        if (cnt_strobe) n_cnt_stb++;
        if (tlr_strobe) n_tlr_stb++;
        if (tcr_strobe) n_tcr_stb++;
        if (rst && b_valid && b_ready) begin
            if (bq.size() == 0) fail_now("b_unexpected");
            else check("b_resp", {30'h0, b_resp}, {30'h0, bq.pop_front()});
        end
        if (rst && r_valid && r_ready) begin
            if (rq.size() == 0) fail_now("r_unexpected");
            else begin
                logic [33:0] e;
                e = rq.pop_front();
                check("r_data", r_data, e[31:0]);
                check("r_resp", {30'h0, r_resp}, {30'h0, e[33:32]});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_aw(input logic [31:0] a, input logic [2:0] p);
        bit hs = 0;
        aw_addr = a; aw_prot = p; aw_valid = 1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk); hs = aw_ready;
            @(posedge clk); #1;
        end
        aw_valid = 0;
        if (!hs) fail_now("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit hs = 0;
        w_data = d; w_strb = s; w_valid = 1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk); hs = w_ready;
            @(posedge clk); #1;
        end
        w_valid = 0;
        if (!hs) fail_now("w_handshake");
    endtask

    // gap > 0: W follows AW by gap cycles; gap < 0: AW follows W.
    task automatic do_write(input logic [31:0] a, d, input logic [3:0] s,
                            input logic [2:0] p, input int gap, input int bdly);
        logic [1:0] er;
        int n = 0;
        model_write(a, d, s, p, er);
        bq.push_back(er);
        fork
            begin if (gap < 0) begin repeat (-gap) @(posedge clk); #1; end send_aw(a, p); end
            begin if (gap > 0) begin repeat (gap) @(posedge clk); #1; end send_w(d, s); end
        join
        while (!b_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!b_valid) begin fail_now("b_valid_wait"); return; end
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            check("b_valid_hold", {31'h0, b_valid}, 32'h1);
            check("aw_ready_busy", {31'h0, aw_ready}, 32'h0);
            check("w_ready_busy", {31'h0, w_ready}, 32'h0);
            @(posedge clk); #1;
        end
        b_ready = 1;
        @(posedge clk); #1;
        b_ready = 0;
        check("b_valid_clear", {31'h0, b_valid}, 32'h0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int rdly);
        logic [33:0] e;
        bit hs = 0;
        int n = 0;
        e = model_read(a, p);
        if (a < 32'h10 && a[3:2] == 2'd2 && prot_ok(p)) e_tcr_stb++;
        rq.push_back(e);
        ar_addr = a; ar_prot = p; ar_valid = 1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk); hs = ar_ready;
            @(posedge clk); #1;
        end
        ar_valid = 0;
        if (!hs) begin fail_now("ar_handshake"); void'(rq.pop_back()); return; end
        tcr_tcr = $urandom;  // the read must keep the value sampled at acceptance
        while (!r_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!r_valid) begin fail_now("r_valid_wait"); return; end
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check("r_data_hold", r_data, e[31:0]);
            @(posedge clk); #1;
        end
        r_ready = 1;
        @(posedge clk); #1;
        r_ready = 0;
    endtask

    task automatic check_outs(input string tag);
        @(negedge clk);
        check({tag, ":cnt"}, {29'h0, cnt_ien, cnt_udt, cnt_ena}, {29'h0, m_cnt});
        check({tag, ":tlr"}, tlr_tlr, m_tlr);
        check({tag, ":irq"}, {31'h0, irq}, {31'h0, m_tir & m_cnt[2]});
        check({tag, ":cnt_stb"}, n_cnt_stb, e_cnt_stb);
        check({tag, ":tlr_stb"}, n_tlr_stb, e_tlr_stb);
        check({tag, ":tcr_stb"}, n_tcr_stb, e_tcr_stb);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ":readys"}, {29'h0, aw_ready, w_ready, ar_ready}, 32'h0);
        check({tag, ":valids"}, {30'h0, b_valid, r_valid}, 32'h0);
        check({tag, ":resps_data"}, {28'h0, b_resp, r_resp} | r_data, 32'h0);
        check({tag, ":strobes_cnt_irq"},
              {25'h0, cnt_strobe, tlr_strobe, tcr_strobe, cnt_ena, cnt_udt, cnt_ien, irq}, 32'h0);
        check({tag, ":tlr"}, tlr_tlr, 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk); rst = 1; #1;
        check("ready_before_first_edge", {29'h0, aw_ready, w_ready, ar_ready}, 32'h0);
        @(negedge clk);
        check("ready_after_first_edge", {29'h0, aw_ready, w_ready, ar_ready}, 32'h7);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [31:0] addr_tab [7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h24, 32'h1000};

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        release_reset();

        // AW first, W two cycles later
        do_write(32'h4, 32'hDEADBEEF, 4'hF, 3'b001, 2, 0);
        check_outs("tlr_write");
        // W first, b_ready held low 3 cycles
        do_write(32'h0, 32'h7, 4'hF, 3'b001, -2, 3);
        check_outs("cnt_write");
        // TCR read sampled at acceptance, r_ready low 2 cycles
        tcr_tcr = 32'h12345678;
        do_read(32'h8, 3'b001, 2);
        check_outs("tcr_read");
        // zero event coincident with W1C: set wins
        tir_zero_set = 1; m_tir = 1;
        do_write(32'hC, 32'h1, 4'hF, 3'b001, 0, 0);
        tir_zero_set = 0;
        check_outs("tir_set_wins");
        do_read(32'hC, 3'b001, 0);
        do_write(32'hC, 32'h1, 4'hF, 3'b001, 1, 0);
        check_outs("tir_w1c");
        // error responses, no strobes
        do_write(32'h20, 32'hFFFFFFFF, 4'hF, 3'b001, 0, 1);
        do_write(32'h8, 32'hFFFFFFFF, 4'hF, 3'b001, 0, 0);
        do_read(32'h20, 3'b001, 1);
        check_outs("slverr");
`ifdef AXILITE_TIMER_PROT_CHK_EN
        do_write(32'h4, 32'h0BADF00D, 4'hF, 3'b000, 0, 0);
        do_read(32'h8, 3'b000, 0);
        check_outs("prot_reject");
`endif

        for (int it = 0; it < 40; it++) begin
            logic [31:0] a;
            a = addr_tab[$urandom_range(0, 6)];
            if ($urandom_range(0, 4) == 0) begin
                tir_zero_set = 1; @(posedge clk); #1; tir_zero_set = 0; m_tir = 1;
            end
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                         $urandom_range(0, 6) - 3, $urandom_range(0, 3));
            else begin
                tcr_tcr = $urandom;
                do_read(a, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
            end
            check_outs("random");
        end

        // reset while an address sits in the holding register
        aw_addr = 32'h4; aw_prot = 3'b001; aw_valid = 1;
        @(posedge clk); #1; aw_valid = 0;
        #2 rst = 0; #1;
        check_reset_outs("mid_reset");
        m_cnt = '0; m_tlr = '0; m_tir = 0;
        release_reset();
        do_write(32'h4, 32'hCAFE0123, 4'hF, 3'b001, 1, 1);
        check_outs("post_reset_write");

        check("bq_drained", bq.size(), 32'h0);
        check("rq_drained", rq.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
